// File: rtl/seq_pkg.sv
// Shared encodings for the sequence generator/detector pair: FSM states and default pattern width.
package seq_pkg;

  localparam int SEQ_PATTERN_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sequence_generator.sv
// Serial MSB-first pattern transmitter with repeat count and idle gaps between frames.
//   state | meaning
//   IDLE  | waiting for start with a legal pat_len
//   SEND  | shifting out pattern bits, out_valid high
//   GAP   | idle cycles between frames, busy still high
//   FIN   | one-cycle done pulse, then back to IDLE
module sequence_generator
  import seq_pkg::*;
#(
  parameter int PATTERN_W = SEQ_PATTERN_W,
  parameter int LEN_W     = 3,
  parameter int REP_W     = 4,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [LEN_W-1:0]     pat_len,
  input  logic [REP_W-1:0]     reps,
  input  logic [GAP_W-1:0]     gap_len,
  output logic                 out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [LEN_W:0] PW_L = (LEN_W+1)'(PATTERN_W);

  seq_state_e           r_state;
  logic [PATTERN_W-1:0] r_pat;
  logic [PATTERN_W-1:0] r_shift;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_bit_cnt;
  logic [REP_W-1:0]     r_frame_cnt;
  logic [GAP_W-1:0]     r_gap;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_out;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_done;

  logic [LEN_W:0]       w_shamt;
  logic [PATTERN_W-1:0] w_aligned;
  logic                 w_len_ok;

  // Left-align the pattern so the first bit to send always sits in the MSB.
  always_comb begin
    w_shamt   = PW_L - {1'b0, pat_len};
    w_aligned = pattern << w_shamt;
    w_len_ok  = (pat_len != '0) && ({1'b0, pat_len} <= PW_L);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_shift     <= '0;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_len_ok) begin
            r_pat       <= w_aligned;
            r_shift     <= w_aligned << 1;
            r_len       <= pat_len;
            r_bit_cnt   <= pat_len - LEN_W'(1);
            r_frame_cnt <= reps;
            r_gap       <= gap_len;
            r_out       <= w_aligned[PATTERN_W-1];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (r_bit_cnt != '0) begin
            r_out     <= r_shift[PATTERN_W-1];
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end else if (r_frame_cnt != '0) begin
            r_frame_cnt <= r_frame_cnt - REP_W'(1);
            if (r_gap != '0) begin
              r_out       <= 1'b0;
              r_out_valid <= 1'b0;
              r_gap_cnt   <= r_gap - GAP_W'(1);
              r_state     <= GAP;
            end else begin
              r_out     <= r_pat[PATTERN_W-1];
              r_shift   <= r_pat << 1;
              r_bit_cnt <= r_len - LEN_W'(1);
            end
          end else begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= FIN;
          end
        end

        GAP: begin
          if (abort) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else begin
            r_out       <= r_pat[PATTERN_W-1];
            r_shift     <= r_pat << 1;
            r_bit_cnt   <= r_len - LEN_W'(1);
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end
        end

        // Abort or not, FIN always returns to IDLE with all outputs low.
        FIN: begin
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end

        default: begin
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: per-cycle expected outputs are queued at start and popped each clock.
module tb_sequence_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [5:0] pattern;
  logic [2:0] pat_len;
  logic [3:0] reps;
  logic [3:0] gap_len;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Each entry: {out, out_valid, busy, done} expected after one rising edge.
  logic [3:0] exp_q[$];

  sequence_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .pat_len   (pat_len),
    .reps      (reps),
    .gap_len   (gap_len),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_sig(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e);
    check_sig({tag, ".out"},       out,       e[3]);
    check_sig({tag, ".out_valid"}, out_valid, e[2]);
    check_sig({tag, ".busy"},      busy,      e[1]);
    check_sig({tag, ".done"},      done,      e[0]);
  endtask

  task automatic push_frames(input logic [5:0] p, input int l, input int r, input int g);
    for (int f = 0; f < r; f++) begin
      for (int i = 0; i < l; i++) exp_q.push_back({p[l-1-i], 1'b1, 1'b1, 1'b0});
      if (f < r - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic step(input string tag);
    logic [3:0] e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    check_all(tag, e);
    @(negedge clk);
  endtask

  task automatic start_frame(input string tag, input logic [5:0] p, input logic [2:0] l,
                             input logic [3:0] r, input logic [3:0] g);
    pattern = p;
    pat_len = l;
    reps    = r;
    gap_len = g;
    start   = 1'b1;
    push_frames(p, int'(l), int'(r) + 1, int'(g));
    step(tag);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    pat_len = '0;
    reps    = '0;
    gap_len = '0;
    #1;
    check_all("reset", 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step("idle");

    start_frame("single", 6'b101101, 3'd6, 4'd0, 4'd0);
    drain("single");

    start_frame("rep_gap", 6'b101101, 3'd6, 4'd2, 4'd2);
    drain("rep_gap");

    start_frame("len1", 6'b000001, 3'd1, 4'd3, 4'd0);
    drain("len1");

    pat_len = 3'd0;
    start   = 1'b1;
    step("len0");
    start = 1'b0;
    step("len0_after");
    pat_len = 3'd7;
    start   = 1'b1;
    step("len7");
    start = 1'b0;
    step("len7_after");

    start_frame("midchg", 6'b101101, 3'd6, 4'd0, 4'd0);
    step("midchg");
    step("midchg");
    pattern = 6'b010010;
    pat_len = 3'd3;
    reps    = 4'd5;
    start   = 1'b1;
    step("midchg");
    start = 1'b0;
    drain("midchg");

    start_frame("abort", 6'b101101, 3'd6, 4'd1, 4'd3);
    step("abort_pre");
    step("abort_pre");
    step("abort_pre");
    abort = 1'b1;
    exp_q.delete();
    step("abort_edge");
    abort = 1'b0;
    start_frame("post_abort", 6'b101101, 3'd6, 4'd0, 4'd0);
    drain("post_abort");
    repeat (4) step("no_late_done");

    abort = 1'b1;
    start_frame("idle_abort", 6'b110011, 3'd6, 4'd0, 4'd0);
    abort = 1'b0;
    drain("idle_abort");

    start_frame("rst_gap", 6'b101101, 3'd6, 4'd2, 4'd2);
    repeat (6) step("rst_gap");
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 4'b0000);
    exp_q.delete();
    step("rst_hold");
    reset = 1'b1;
    start_frame("post_reset", 6'b101101, 3'd6, 4'd0, 4'd0);
    drain("post_reset");
    step("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
